// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: multiplexed N-digit 7-segment scan controller.
// It divides the system clock down to a per-digit scan tick and steps a
// one-hot digit select. Each digit's nibble is encoded to a segment font.
// Display data is snapshotted at the start of every frame so that input
// changes never tear a frame. The controller also supports per-digit
// decimal point and blanking, optional leading-zero suppression, and
// configurable output polarity.
module fnd_scan_ctrl #(
    parameter int DIGITS         = 4,
    parameter int CLK_HZ         = 100_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int BLANK_LZ       = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_enable,
    input  logic [4*DIGITS-1:0] i_digits,
    input  logic [DIGITS-1:0]   i_dp,
    input  logic [DIGITS-1:0]   i_blank,
    output logic [DIGITS-1:0]   o_fndselect,
    output logic [7:0]          o_fndfont,
    output logic                o_frame_start
);

    localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned IDX_W = $clog2(DIGITS);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_OFF  = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [7:0]        FONT_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble
    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    logic [CNT_W-1:0]    r_prescale;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_snap_digits;
    logic [DIGITS-1:0]   r_snap_dp;
    logic [DIGITS-1:0]   r_snap_blank;
    logic [DIGITS-1:0]   r_sel;
    logic [7:0]          r_font;
    logic                r_frame_start;

    logic                w_tick;
    logic                w_first;
    logic [4*DIGITS-1:0] w_cur_digits;
    logic [DIGITS-1:0]   w_cur_dp;
    logic [DIGITS-1:0]   w_cur_blank;
    logic                w_upper_zero;
    logic [3:0]          w_nib;
    logic                w_dp;
    logic                w_blk;
    logic                w_lz;
    logic [7:0]          w_byte;
    logic [7:0]          w_font_drive;
    logic [DIGITS-1:0]   w_onehot;
    logic [DIGITS-1:0]   w_sel_drive;

    assign w_tick  = i_enable && (r_prescale == CNT_LAST);
    assign w_first = (r_idx == '0);

    // Digit 0 is driven on the same edge that captures the snapshot, so that
    // digit reads straight from the inputs; later digits read the snapshot.
    always_comb begin
        w_cur_digits = w_first ? i_digits : r_snap_digits;
        w_cur_dp     = w_first ? i_dp     : r_snap_dp;
        w_cur_blank  = w_first ? i_blank  : r_snap_blank;
    end

    // Select the current digit's data and work out leading-zero suppression
    // by scanning from the most significant digit downwards.
    always_comb begin
        w_nib        = '0;
        w_dp         = 1'b0;
        w_blk        = 1'b0;
        w_lz         = 1'b0;
        w_upper_zero = 1'b1;
        w_onehot     = '0;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            if (w_cur_digits[4*(DIGITS-1-j) +: 4] != 4'h0) begin
                w_upper_zero = 1'b0;
            end
            if (r_idx == IDX_W'(DIGITS-1-j)) begin
                w_nib = w_cur_digits[4*(DIGITS-1-j) +: 4];
                w_dp  = w_cur_dp[DIGITS-1-j];
                w_blk = w_cur_blank[DIGITS-1-j];
                w_lz  = (BLANK_LZ != 0) && (DIGITS-1-j != 0) && w_upper_zero;
            end
        end
        for (int unsigned j = 0; j < DIGITS; j++) begin
            w_onehot[j] = (r_idx == IDX_W'(j));
        end
    end

    // Build the font byte and select word in output polarity
    always_comb begin
        w_byte       = (w_blk || w_lz) ? 8'h00 : {w_dp, hex_font(w_nib)};
        w_font_drive = (SEG_ACTIVE_LOW != 0) ? ~w_byte : w_byte;
        w_sel_drive  = (SEL_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
    end

    // Scan-rate prescaler: runs only while enabled, restarts from zero otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prescale <= '0;
        end else if (!i_enable || (r_prescale == CNT_LAST)) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + 1'b1;
        end
    end

    // Digit index and frame snapshot advance on each scan tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx         <= '0;
            r_snap_digits <= '0;
            r_snap_dp     <= '0;
            r_snap_blank  <= '0;
        end else if (w_tick) begin
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            if (w_first) begin
                r_snap_digits <= i_digits;
                r_snap_dp     <= i_dp;
                r_snap_blank  <= i_blank;
            end
        end
    end

    // Registered pin drive: select and font always update on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel         <= SEL_OFF;
            r_font        <= FONT_OFF;
            r_frame_start <= 1'b0;
        end else if (!i_enable) begin
            r_sel         <= SEL_OFF;
            r_font        <= FONT_OFF;
            r_frame_start <= 1'b0;
        end else if (w_tick) begin
            r_sel         <= w_sel_drive;
            r_font        <= w_font_drive;
            r_frame_start <= w_first;
        end else begin
            r_frame_start <= 1'b0;
        end
    end

    assign o_fndselect   = r_sel;
    assign o_fndfont     = r_font;
    assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Testbench for fnd_scan_ctrl: 4 digits, DIV=10, active-low pins.
// Two instances share stimulus, one with leading-zero suppression and one
// without. The expected pin changes are queued with the cycle at which they
// must appear, and a monitor pops and compares them on every output change.
module tb_fnd_scan_ctrl;

    logic        clk;
    logic        reset;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  sel,  sel0;
    logic [7:0]  font, font0;
    logic        fs,   fs0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [3:0] sel;
        logic [7:0] font;
        logic [7:0] font0;
        logic       fs;
    } exp_t;

    exp_t exp_q[$];
    logic [11:0] prev = 12'hFFF;

    fnd_scan_ctrl #(
        .DIGITS(4), .CLK_HZ(10), .SCAN_HZ(1),
        .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1), .BLANK_LZ(1)
    ) dut (
        .clk(clk), .reset(reset), .i_enable(en), .i_digits(digits),
        .i_dp(dp), .i_blank(blank), .o_fndselect(sel), .o_fndfont(font),
        .o_frame_start(fs)
    );

    fnd_scan_ctrl #(
        .DIGITS(4), .CLK_HZ(10), .SCAN_HZ(1),
        .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1), .BLANK_LZ(0)
    ) dut_nolz (
        .clk(clk), .reset(reset), .i_enable(en), .i_digits(digits),
        .i_dp(dp), .i_blank(blank), .o_fndselect(sel0), .o_fndfont(font0),
        .o_frame_start(fs0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Active-low font byte for digit k of a 4-digit value
    function automatic logic [7:0] exp_font(input logic [15:0] d, input logic [3:0] p,
                                            input logic [3:0] b, input int k, input bit lz);
        logic [15:0] upper;
        logic [7:0]  lit;
        upper = d >> (4 * k);
        if (b[k] || (lz && k > 0 && upper == 16'h0)) lit = 8'h00;
        else                                         lit = {p[k], seg7(upper[3:0])};
        return ~lit;
    endfunction

    task automatic push_digit(input int c, input int k, input logic [15:0] d,
                              input logic [3:0] p, input logic [3:0] b);
        exp_t e;
        logic [3:0] oh;
        oh      = 4'b0001 << k;
        e.cyc   = c;
        e.sel   = ~oh;
        e.font  = exp_font(d, p, b, k, 1'b1);
        e.font0 = exp_font(d, p, b, k, 1'b0);
        e.fs    = (k == 0);
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input int c0, input logic [15:0] d,
                              input logic [3:0] p, input logic [3:0] b);
        for (int k = 0; k < 4; k++) push_digit(c0 + 10 * k, k, d, p, b);
    endtask

    task automatic push_dark(input int c);
        exp_t e;
        e.cyc = c; e.sel = 4'hF; e.font = 8'hFF; e.font0 = 8'hFF; e.fs = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every change of select/font must match the next queued entry
    always @(negedge clk) begin
        exp_t e;
        if ({sel, font} !== prev) begin
            if (exp_q.size() == 0) begin
                check("spurious_output_change", {20'd0, sel, font}, {20'd0, prev});
            end else begin
                e = exp_q.pop_front();
                check("change_cycle", cyc, e.cyc);
                check("sel",          {28'd0, sel},  {28'd0, e.sel});
                check("font",         {24'd0, font}, {24'd0, e.font});
                check("frame_start",  {31'd0, fs},   {31'd0, e.fs});
                check("sel_nolz",     {28'd0, sel0}, {28'd0, e.sel});
                check("font_nolz",    {24'd0, font0}, {24'd0, e.font0});
                check("fs_nolz",      {31'd0, fs0},  {31'd0, e.fs});
            end
            prev = {sel, font};
        end else begin
            check("fs_idle", {31'd0, fs}, 32'd0);
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: stimulus did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int s;
        int r;
        reset  = 1'b1;
        en     = 1'b0;
        digits = 16'h1234;
        dp     = 4'h0;
        blank  = 4'h0;
        repeat (3) @(negedge clk);
        check("reset_sel",  {28'd0, sel},  32'hF);
        check("reset_font", {24'd0, font}, 32'hFF);
        check("reset_fs",   {31'd0, fs},   32'd0);

        s = cyc;
        push_frame(s + 10,  16'h1234, 4'h0, 4'h0);
        push_frame(s + 50,  16'hFFFF, 4'h0, 4'h0);
        push_frame(s + 90,  16'h0050, 4'h0, 4'h0);
        push_frame(s + 130, 16'h0000, 4'h0, 4'h0);
        push_frame(s + 170, 16'h8888, 4'b0010, 4'b0001);
        push_frame(s + 210, 16'h0008, 4'b0010, 4'b0000);
        push_digit(s + 250, 0, 16'h1234, 4'h0, 4'h0);
        push_digit(s + 260, 1, 16'h1234, 4'h0, 4'h0);
        push_dark(s + 266);
        push_digit(s + 285, 2, 16'h1234, 4'h0, 4'h0);
        push_digit(s + 295, 3, 16'h1234, 4'h0, 4'h0);
        push_dark(s + 301);

        reset = 1'b0;
        en    = 1'b1;

        // Change mid-frame while digit 1 is displayed: the frame must not tear
        wait_cyc(s + 25);  digits = 16'hFFFF;
        wait_cyc(s + 85);  digits = 16'h0050;
        wait_cyc(s + 125); digits = 16'h0000;
        wait_cyc(s + 165); digits = 16'h8888; dp = 4'b0010; blank = 4'b0001;
        wait_cyc(s + 205); digits = 16'h0008; dp = 4'b0010; blank = 4'b0000;
        wait_cyc(s + 245); digits = 16'h1234; dp = 4'b0000; blank = 4'b0000;

        // Drop enable with idx=2, then resume from digit 2
        wait_cyc(s + 265); en = 1'b0;
        wait_cyc(s + 275); en = 1'b1;

        // Asynchronous reset between clock edges
        wait_cyc(s + 300);
        #2 reset = 1'b1;
        #1;
        check("async_rst_sel",       {28'd0, sel},   32'hF);
        check("async_rst_font",      {24'd0, font},  32'hFF);
        check("async_rst_fs",        {31'd0, fs},    32'd0);
        check("async_rst_sel_nolz",  {28'd0, sel0},  32'hF);
        check("async_rst_font_nolz", {24'd0, font0}, 32'hFF);

        wait_cyc(s + 304);
        r = cyc;
        push_digit(r + 10, 0, 16'h1234, 4'h0, 4'h0);
        push_digit(r + 20, 1, 16'h1234, 4'h0, 4'h0);
        reset = 1'b0;

        wait_cyc(r + 25);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
